// File: rtl/alu_drv_pkg.sv
// Shared types and constants for the ALU command driver.
package alu_drv_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_RESP  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    localparam logic [2:0] IDLE_SEL    = 3'b000;
    localparam logic [2:0] RST_SEL     = 3'b001;
    localparam logic [2:0] LOAD_SEL    = 3'b010;
    localparam logic [2:0] PERSIST_SEL = 3'b100;

    // ALU control word presented while the driver sits in a given state.
    function automatic logic [2:0] sel_for_state(input state_t s);
        case (s)
            ST_LOAD:          return LOAD_SEL;
            ST_EXEC, ST_RESP: return PERSIST_SEL;
            ST_CLEAR:         return RST_SEL;
            default:          return IDLE_SEL;
        endcase
    endfunction

    // True when exactly one bit of the operation select is set.
    function automatic logic is_one_hot(input logic [OP_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command/response handshake bundle between a requester and the ALU driver.
interface alu_cmd_driver_if;
    import alu_drv_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [OP_W-1:0]   req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_drv_lat_cnt.sv
// 4-bit down-counter timing the ALU settle window.
module alu_drv_lat_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/alu_cmd_driver.sv
// Sequences one ALU operation per accepted command: load, settle, capture, clear.
//   state | meaning
//   IDLE  | ready for a command, ALU control idle
//   LOAD  | one-cycle load pulse with operands applied
//   EXEC  | persist for LAT cycles while the ALU settles
//   RESP  | result (or rejection) offered until consumed
//   CLEAR | one-cycle ALU reset pulse before returning to IDLE
module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_driver_if.slave     bus,
    output logic [2:0]          in_sel,
    output logic [DATA_W-1:0]   num1,
    output logic [DATA_W-1:0]   num2,
    output logic [OP_W-1:0]     out_sel,
    input  logic [DATA_W-1:0]   alu_out
);

    // The counter runs LAT-1 down to 0 so the zero flag marks the last EXEC cycle.
    localparam logic [3:0] LAT_LOAD = 4'(LAT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [2:0]        r_in_sel;
    logic [DATA_W-1:0] r_num1;
    logic [DATA_W-1:0] r_num2;
    logic [OP_W-1:0]   r_out_sel;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              w_accept;
    logic              w_op_ok;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_zero;

    assign w_op_ok = is_one_hot(bus.req_op);

    alu_drv_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (LAT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Next-state and counter control.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = w_op_ok ? ST_LOAD : ST_RESP;
                end
            end
            ST_LOAD: begin
                w_cnt_load   = 1'b1;
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_cnt_zero) w_next_state = ST_RESP;
                else            w_cnt_dec    = 1'b1;
            end
            ST_RESP: begin
                if (bus.rsp_ready) w_next_state = r_rsp_err ? ST_IDLE : ST_CLEAR;
            end
            ST_CLEAR: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State register plus outputs registered from the upcoming state, so ALU
    // control never has a combinational path from the handshake inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_sel    <= IDLE_SEL;
            r_num1      <= '0;
            r_num2      <= '0;
            r_out_sel   <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_sel    <= sel_for_state(w_next_state);
            r_req_ready <= (w_next_state == ST_IDLE);
            r_rsp_valid <= (w_next_state == ST_RESP);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_op_ok) begin
                            r_num1    <= bus.req_a;
                            r_num2    <= bus.req_b;
                            r_out_sel <= bus.req_op;
                        end else begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (w_cnt_zero) begin
                        r_rsp_data <= alu_out;
                        r_rsp_err  <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_num1    <= '0;
                        r_num2    <= '0;
                        r_out_sel <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign in_sel        = r_in_sel;
    assign num1          = r_num1;
    assign num2          = r_num2;
    assign out_sel       = r_out_sel;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: LAT=2 instance for the main scenarios,
// LAT=15 instance for the long settle window.
module tb_alu_cmd_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [2:0] in_sel2,  in_sel15;
    logic [7:0] num1_2,   num1_15;
    logic [7:0] num2_2,   num2_15;
    logic [5:0] out_sel2, out_sel15;
    logic [7:0] alu_out2, alu_out15;

    int n_tests = 0;
    int n_fail  = 0;

    alu_cmd_driver_if bus2 ();
    alu_cmd_driver_if bus15 ();

    alu_cmd_driver #(.LAT(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus2),
        .in_sel  (in_sel2),
        .num1    (num1_2),
        .num2    (num2_2),
        .out_sel (out_sel2),
        .alu_out (alu_out2)
    );

    alu_cmd_driver #(.LAT(15)) dut15 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus15),
        .in_sel  (in_sel15),
        .num1    (num1_15),
        .num2    (num2_15),
        .out_sel (out_sel15),
        .alu_out (alu_out15)
    );

    // ALU stub: bit0 add, bit1 subtract, otherwise AND.
    assign alu_out2  = out_sel2[0]  ? num1_2 + num2_2   : (out_sel2[1]  ? num1_2 - num2_2   : num1_2 & num2_2);
    assign alu_out15 = out_sel15[0] ? num1_15 + num2_15 : (out_sel15[1] ? num1_15 - num2_15 : num1_15 & num2_15);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send2(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        bus2.req_valid = 1'b1;
        bus2.req_a     = a;
        bus2.req_b     = b;
        bus2.req_op    = op;
    endtask

    initial begin
        int n_persist;
        int cyc;

        bus2.req_valid  = 1'b0; bus2.req_a  = '0; bus2.req_b  = '0; bus2.req_op  = '0; bus2.rsp_ready  = 1'b1;
        bus15.req_valid = 1'b0; bus15.req_a = '0; bus15.req_b = '0; bus15.req_op = '0; bus15.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready",   32'(bus2.req_ready), 32'h0);
        chk("rst_in_sel",  32'(in_sel2),        32'h0);
        chk("rst_valid",   32'(bus2.rsp_valid), 32'h0);
        chk("rst_data",    32'(bus2.rsp_data),  32'h0);
        chk("rst_num1",    32'(num1_2),         32'h0);
        rst = 1'b0;
        #1;
        chk("rel_ready_before_edge", 32'(bus2.req_ready), 32'h0);
        @(negedge clk);
        chk("rel_ready_after_edge",  32'(bus2.req_ready), 32'h1);

        // Legal add: 0x57 + 0x1A
        send2(8'h57, 8'h1A, 6'b000001);
        @(negedge clk);                       // cycle 1
        bus2.req_valid = 1'b0;
        chk("add_c1_in_sel",  32'(in_sel2),        32'h2);
        chk("add_c1_num1",    32'(num1_2),         32'h57);
        chk("add_c1_num2",    32'(num2_2),         32'h1A);
        chk("add_c1_out_sel", 32'(out_sel2),       32'h01);
        chk("add_c1_ready",   32'(bus2.req_ready), 32'h0);
        chk("add_c1_valid",   32'(bus2.rsp_valid), 32'h0);
        @(negedge clk);                       // cycle 2
        chk("add_c2_in_sel",  32'(in_sel2),        32'h4);
        chk("add_c2_num1",    32'(num1_2),         32'h57);
        @(negedge clk);                       // cycle 3
        chk("add_c3_in_sel",  32'(in_sel2),        32'h4);
        chk("add_c3_valid",   32'(bus2.rsp_valid), 32'h0);
        @(negedge clk);                       // cycle 4
        chk("add_c4_valid",   32'(bus2.rsp_valid), 32'h1);
        chk("add_c4_data",    32'(bus2.rsp_data),  32'h71);
        chk("add_c4_err",     32'(bus2.rsp_err),   32'h0);
        @(negedge clk);                       // cycle 5
        chk("add_c5_clear",   32'(in_sel2),        32'h1);
        chk("add_c5_valid",   32'(bus2.rsp_valid), 32'h0);
        chk("add_c5_num1",    32'(num1_2),         32'h0);
        @(negedge clk);                       // cycle 6
        chk("add_c6_idle",    32'(in_sel2),        32'h0);
        chk("add_c6_ready",   32'(bus2.req_ready), 32'h1);

        // Rejected op: two bits set
        send2(8'h12, 8'h34, 6'b000011);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        chk("rej_valid",  32'(bus2.rsp_valid), 32'h1);
        chk("rej_err",    32'(bus2.rsp_err),   32'h1);
        chk("rej_data",   32'(bus2.rsp_data),  32'h0);
        chk("rej_in_sel", 32'(in_sel2),        32'h4);
        chk("rej_num1",   32'(num1_2),         32'h0);
        @(negedge clk);
        chk("rej_no_clear", 32'(in_sel2),        32'h0);
        chk("rej_ready",    32'(bus2.req_ready), 32'h1);

        // Rejected op: zero
        send2(8'h12, 8'h34, 6'b000000);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        chk("zero_op_err", 32'(bus2.rsp_err), 32'h1);
        @(negedge clk);
        chk("zero_op_ready", 32'(bus2.req_ready), 32'h1);

        // Back-pressure: rsp_ready low for 5 RESP cycles, subtract 0x10-0x05
        bus2.rsp_ready = 1'b0;
        send2(8'h10, 8'h05, 6'b000010);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        repeat (3) @(negedge clk);            // cycle 4
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  32'(bus2.rsp_valid), 32'h1);
            chk("bp_data",   32'(bus2.rsp_data),  32'h0B);
            chk("bp_in_sel", 32'(in_sel2),        32'h4);
            if (i == 4) bus2.rsp_ready = 1'b1;
            @(negedge clk);
        end
        chk("bp_clear", 32'(in_sel2), 32'h1);
        @(negedge clk);
        chk("bp_idle", 32'(in_sel2), 32'h0);

        // req_valid held while busy with different operands
        send2(8'h20, 8'h03, 6'b000001);
        @(negedge clk);                       // cycle 1
        send2(8'hAA, 8'h55, 6'b000001);
        chk("busy_c1_num1",  32'(num1_2),         32'h20);
        @(negedge clk);                       // cycle 2
        chk("busy_c2_num1",  32'(num1_2),         32'h20);
        chk("busy_c2_ready", 32'(bus2.req_ready), 32'h0);
        @(negedge clk);                       // cycle 3
        chk("busy_c3_num2",  32'(num2_2),         32'h03);
        @(negedge clk);                       // cycle 4
        chk("busy_c4_data",  32'(bus2.rsp_data),  32'h23);
        @(negedge clk);                       // cycle 5
        chk("busy_c5_clear", 32'(in_sel2),        32'h1);
        chk("busy_c5_ready", 32'(bus2.req_ready), 32'h0);
        @(negedge clk);                       // cycle 6
        chk("busy_c6_ready", 32'(bus2.req_ready), 32'h1);
        @(negedge clk);                       // cycle 7
        bus2.req_valid = 1'b0;
        chk("busy_c7_load",  32'(in_sel2),        32'h2);
        chk("busy_c7_num1",  32'(num1_2),         32'hAA);
        repeat (3) @(negedge clk);            // cycle 10
        chk("busy_c10_data", 32'(bus2.rsp_data),  32'hFF);
        @(negedge clk);
        chk("busy_c11_clear", 32'(in_sel2), 32'h1);
        @(negedge clk);
        chk("busy_c12_ready", 32'(bus2.req_ready), 32'h1);

        // Reset asserted during EXEC
        send2(8'h01, 8'h02, 6'b000001);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        @(negedge clk);                       // EXEC
        #2 rst = 1'b1;
        #1;
        chk("arst_in_sel",  32'(in_sel2),        32'h0);
        chk("arst_num1",    32'(num1_2),         32'h0);
        chk("arst_out_sel", 32'(out_sel2),       32'h0);
        chk("arst_ready",   32'(bus2.req_ready), 32'h0);
        chk("arst_valid",   32'(bus2.rsp_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_rel_ready", 32'(bus2.req_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("arst_no_rsp",   32'(bus2.rsp_valid), 32'h0);
            chk("arst_no_clear", 32'(in_sel2),        32'h0);
            @(negedge clk);
        end

        // LAT=15: 0x00 + 0x01
        bus15.req_valid = 1'b1;
        bus15.req_a     = 8'h00;
        bus15.req_b     = 8'h01;
        bus15.req_op    = 6'b000001;
        @(negedge clk);
        bus15.req_valid = 1'b0;
        chk("l15_load", 32'(in_sel15), 32'h2);
        n_persist = 0;
        cyc       = 1;
        while (!bus15.rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (in_sel15 == 3'b100 && !bus15.rsp_valid) n_persist++;
        end
        chk("l15_valid",   32'(bus15.rsp_valid), 32'h1);
        chk("l15_persist", 32'(n_persist),       32'd15);
        chk("l15_latency", 32'(cyc),             32'd17);
        chk("l15_data",    32'(bus15.rsp_data),  32'h01);
        chk("l15_err",     32'(bus15.rsp_err),   32'h0);
        @(negedge clk);
        chk("l15_clear", 32'(in_sel15), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 SHALL have parameter LAT, default 2, legal range 1..15: ALU settle cycles between load and capture.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: command offered.
REQ-005 SHALL have port req_ready, output, 1 bit: driver accepts a command this cycle.
REQ-006 SHALL have ports req_a and req_b, input, 8 bits each: operands.
REQ-007 SHALL have port req_op, input, 6 bits: operation select, must be one-hot.
REQ-008 SHALL have port in_sel, output, 3 bits: ALU control {persist, load, reset}.
REQ-009 SHALL have ports num1 and num2, output, 8 bits each: ALU operands.
REQ-010 SHALL have port out_sel, output, 6 bits: ALU operation select.
REQ-011 SHALL have port alu_out, input, 8 bits: ALU result.
REQ-012 SHALL have port rsp_valid, output, 1 bit: result available.
REQ-013 SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-014 SHALL have port rsp_data, output, 8 bits: captured result.
REQ-015 SHALL have port rsp_err, output, 1 bit: command rejected because req_op was not one-hot.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, EXEC, RESP, CLEAR.
REQ-017 SHALL, in IDLE, drive req_ready=1 and in_sel=000; in every other state req_ready SHALL be 0.
REQ-018 SHALL accept a command when req_valid and req_ready are both 1, registering req_a, req_b and req_op.
REQ-019 SHALL, on accepting a one-hot req_op, go to LOAD.
REQ-020 SHALL, on accepting a req_op that is not one-hot (zero or several bits set), go directly to RESP with rsp_err=1 and rsp_data=0x00, and SHALL not drive load.
REQ-021 SHALL, in LOAD, drive in_sel=010 for exactly 1 cycle with num1, num2 and out_sel equal to the registered command, then go to EXEC.
REQ-022 SHALL, in EXEC, drive in_sel=100 (persist) for exactly LAT cycles, counted by a 4-bit down-counter; num1, num2 and out_sel SHALL stay stable.
REQ-023 SHALL, on the last EXEC cycle, capture alu_out into rsp_data, clear rsp_err and go to RESP.
REQ-024 SHALL make the total latency from the acceptance edge to rsp_valid=1 equal to LAT+2 cycles for a legal command and 1 cycle for a rejected one.
REQ-025 SHALL, in RESP, hold rsp_valid=1 with rsp_data and rsp_err stable until rsp_ready=1, and SHALL drive in_sel=100 while waiting.
REQ-026 SHALL, on the RESP handshake, go to CLEAR for a legal command and to IDLE for a rejected one.
REQ-027 SHALL, in CLEAR, drive in_sel=001 for 1 cycle, then go to IDLE.
REQ-028 SHALL keep rsp_valid=0 in every state except RESP.
REQ-029 SHALL drive num1, num2 and out_sel to 0 in IDLE and CLEAR.
REQ-030 SHALL drive in_sel with at most one bit set in every cycle; in_sel SHALL be registered (no combinational path from inputs).
REQ-031 SHALL ignore req_valid while busy; no command is queued.
REQ-032 SHALL accept a new command in the first IDLE cycle after CLEAR (back-to-back throughput LAT+4 cycles when rsp_ready is held at 1).

Reset
REQ-033 SHALL, while rst=1, force state IDLE, req_ready=0, in_sel=000, num1=num2=0, out_sel=0, rsp_valid=0, rsp_data=0, rsp_err=0 and counter=0.
REQ-034 SHALL, when rst asserts mid-operation, abandon the command with no response and no CLEAR pulse.
REQ-035 SHALL drive req_ready=1 on the first clk edge after rst deasserts.

Structure
REQ-036 SHALL take the state encoding and the in_sel constants (IDLE_SEL=000, RST_SEL=001, LOAD_SEL=010, PERSIST_SEL=100) from the shared package alu_drv_pkg.
REQ-037 SHALL place the LAT down-counter in sub-module alu_drv_lat_cnt (load, decrement, zero flag).

Verification
REQ-038 SHALL verify, with LAT=2 and a bench ALU stub in which out_sel bit0 selects add: request a=0x57, b=0x1A, op=000001 -> in_sel sequence 010,100,100, then rsp_data=0x71 and rsp_err=0 on cycle 4 after acceptance.
REQ-039 SHALL verify op=000011 -> rsp_err=1, rsp_data=0x00, no 010 pulse on in_sel, and no CLEAR pulse.
REQ-040 SHALL verify rsp_ready held at 0 for 5 cycles -> rsp_valid and rsp_data stable and in_sel=100 throughout, followed by a 001 pulse after the handshake.
REQ-041 SHALL verify req_valid held at 1 during EXEC with different operands -> operands ignored, num1 stable, the second command accepted only after CLEAR.
REQ-042 SHALL verify rst pulsed during EXEC -> all outputs 0 asynchronously, no response produced, req_ready=1 after release.
REQ-043 SHALL verify LAT=15 with a=0x00, b=0x01, op=000001 -> exactly 15 persist cycles and rsp_data=0x01.
